// File: rtl/ebn_pkg.sv
// Shared sizing and pointer-wrap helpers for the ebn elastic buffer.
package ebn_pkg;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ebn_mem.sv
// Flop-array storage for ebn: one write port, one asynchronous read port, no reset.
module ebn_mem
    import ebn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_width(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [ptr_width(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ebn.sv
// N-entry elastic buffer with registered t0_ready, occupancy count, almost-full and flush.
// Optional zero-latency empty-buffer bypass enabled by defining EBN_BYPASS_EN.
module ebn
    import ebn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AFULL = DEPTH - 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            t0_data,
    input  logic                        t0_valid,
    output logic                        t0_ready,
    output logic                        t0_afull,
    output logic [WIDTH-1:0]            i0_data,
    output logic                        i0_valid,
    input  logic                        i0_ready,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             ready_reg, valid_reg, afull_reg;
    logic [WIDTH-1:0] head_data;
    logic             push, pop, pass, wr_en, rd_en;

`ifdef EBN_BYPASS_EN
    logic bypass;

    // An empty buffer presents the incoming word directly; it is stored only if not taken.
    assign bypass   = ~valid_reg & t0_valid;
    assign i0_valid = valid_reg | bypass;
    assign i0_data  = bypass ? t0_data : head_data;
    assign pass     = bypass & i0_ready;
`else
    assign i0_valid = valid_reg;
    assign i0_data  = head_data;
    assign pass     = 1'b0;
`endif

    assign t0_ready = ready_reg;
    assign t0_afull = afull_reg;
    assign count    = count_reg;

    assign push  = t0_valid & ready_reg;
    assign pop   = i0_valid & i0_ready;
    assign wr_en = push & ~pass;
    assign rd_en = pop & ~pass;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (reset || flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_next = PW'(next_ptr(int'(wr_ptr_reg), DEPTH));
            end
            if (rd_en) begin
                rd_ptr_next = PW'(next_ptr(int'(rd_ptr_reg), DEPTH));
            end
            case ({wr_en, rd_en})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Status flags are recomputed from the next count so they come straight off flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
            valid_reg  <= 1'b0;
            afull_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ready_reg  <= (count_next != FULL_CNT);
            valid_reg  <= (count_next != '0);
            afull_reg  <= (count_next >= AFULL_CNT);
        end
    end

    ebn_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en & ~flush & ~reset),
        .waddr (wr_ptr_reg),
        .wdata (t0_data),
        .raddr (rd_ptr_reg),
        .rdata (head_data)
    );

endmodule

// File: tb/tb_ebn.sv
// Directed and random-backpressure bench for ebn (DEPTH=4 directed, DEPTH=3 random).
module tb_ebn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_flush, a_tvalid, a_tready, a_afull, a_ivalid, a_iready;
    logic [7:0] a_tdata, a_idata;
    logic [2:0] a_count;

    logic       b_reset, b_flush, b_tvalid, b_tready, b_afull, b_ivalid, b_iready;
    logic [7:0] b_tdata, b_idata;
    logic [1:0] b_count;

    ebn #(.WIDTH(8), .DEPTH(4)) u_ebn4 (
        .clk(clk), .reset(a_reset), .flush(a_flush),
        .t0_data(a_tdata), .t0_valid(a_tvalid), .t0_ready(a_tready), .t0_afull(a_afull),
        .i0_data(a_idata), .i0_valid(a_ivalid), .i0_ready(a_iready), .count(a_count)
    );

    ebn #(.WIDTH(8), .DEPTH(3)) u_ebn3 (
        .clk(clk), .reset(b_reset), .flush(b_flush),
        .t0_data(b_tdata), .t0_valid(b_tvalid), .t0_ready(b_tready), .t0_afull(b_afull),
        .i0_data(b_idata), .i0_valid(b_ivalid), .i0_ready(b_iready), .count(b_count)
    );

    int n_vec = 0;
    int n_err = 0;
    bit quiet = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end else if (!quiet) begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    int         mc;
    bit         e_iv, e_push, e_pop, e_pass;
    logic [7:0] e_head, e_data;
    int         e_cnt;

    initial begin
        a_reset = 1'b1; a_flush = 1'b0; a_tvalid = 1'b0; a_tdata = '0; a_iready = 1'b0;
        b_reset = 1'b1; b_flush = 1'b0; b_tvalid = 1'b0; b_tdata = '0; b_iready = 1'b0;
        tick();
        tick();
        check("rst_ready", a_tready, 1);
        check("rst_valid", a_ivalid, 0);
        check("rst_count", a_count, 0);
        check("rst_afull", a_afull, 0);
        check("rst3_count", b_count, 0);
        a_reset = 1'b0;

        // Fill without drain
        a_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_tdata = 8'(8'h11 * (i + 1));
            tick();
            check("fill_count", a_count, i + 1);
            check("fill_afull", a_afull, (i + 1 >= 3));
            check("fill_ready", a_tready, (i + 1 != 4));
        end
        a_tdata = 8'h55;
        tick();
        check("full_hold_count", a_count, 4);
        check("full_hold_ready", a_tready, 0);
        check("full_head", a_idata, 8'h11);

        // Drain in order
        a_tvalid = 1'b0;
        a_iready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", a_ivalid, 1);
            check("drain_data", a_idata, 8'(8'h11 * (i + 1)));
            tick();
        end
        check("drain_count", a_count, 0);
        check("drain_valid_end", a_ivalid, 0);
        check("drain_afull", a_afull, 0);

        // Pointer wrap: slots 0,1,2 then 3,0,1
        a_iready = 1'b0;
        a_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_tdata = 8'(8'h61 + i);
            tick();
        end
        check("wrap_fill_count", a_count, 3);
        a_iready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_tdata = 8'(8'h64 + i);
            #1;
            check("wrap_mid_data", a_idata, 8'(8'h61 + i));
            tick();
            check("wrap_mid_count", a_count, 3);
        end
        a_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wrap_tail_data", a_idata, 8'(8'h64 + i));
            tick();
        end
        check("wrap_end_count", a_count, 0);

        // Streaming 0..99
        quiet = 1'b1;
        a_tvalid = 1'b1;
        a_iready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_tdata = 8'(i);
            #1;
`ifdef EBN_BYPASS_EN
            e_iv = 1'b1; e_data = 8'(i); e_cnt = 0;
`else
            e_iv = (i != 0); e_data = 8'(i - 1); e_cnt = (i == 0) ? 0 : 1;
`endif
            check("stream_valid", a_ivalid, e_iv);
            check("stream_count", a_count, e_cnt);
            if (e_iv) check("stream_data", a_idata, e_data);
            tick();
        end
        quiet = 1'b0;
        a_tvalid = 1'b0;
        #1;
`ifdef EBN_BYPASS_EN
        e_iv = 1'b0;
`else
        e_iv = 1'b1;
        check("stream_last", a_idata, 8'd99);
`endif
        check("stream_last_valid", a_ivalid, e_iv);
        tick();
        check("stream_end_count", a_count, 0);
        a_iready = 1'b0;

        // Flush mid-stream with simultaneous push and pop
        a_tvalid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_tdata = 8'(i);
            tick();
        end
        check("pre_flush_count", a_count, 3);
        a_flush = 1'b1;
        a_tdata = 8'h04;
        a_iready = 1'b1;
        tick();
        a_flush = 1'b0; a_tvalid = 1'b0; a_iready = 1'b0;
        #1;
        check("flush_count", a_count, 0);
        check("flush_valid", a_ivalid, 0);
        check("flush_ready", a_tready, 1);
        a_tvalid = 1'b1;
        a_tdata = 8'hAA;
        tick();
        a_tvalid = 1'b0;
        #1;
        check("post_flush_valid", a_ivalid, 1);
        check("post_flush_data", a_idata, 8'hAA);
        check("post_flush_count", a_count, 1);
        a_iready = 1'b1;
        tick();
        a_iready = 1'b0;
        check("post_flush_drain", a_count, 0);

`ifdef EBN_BYPASS_EN
        a_tvalid = 1'b1;
        a_iready = 1'b1;
        a_tdata = 8'h5A;
        #1;
        check("bypass_valid", a_ivalid, 1);
        check("bypass_data", a_idata, 8'h5A);
        tick();
        a_tvalid = 1'b0;
        a_iready = 1'b0;
        check("bypass_count", a_count, 0);
`endif

        // Random back-pressure on the DEPTH=3 instance against a queue model
        b_reset = 1'b0;
        quiet = 1'b1;
        mc = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            b_tvalid = ($urandom_range(9) < 7);
            b_iready = ($urandom_range(9) >= 2);
            b_tdata  = 8'($urandom);
            #1;
            e_push = b_tvalid && (mc != 3);
`ifdef EBN_BYPASS_EN
            e_iv   = (mc != 0) || b_tvalid;
            e_pass = (mc == 0) && b_tvalid && b_iready;
            e_head = (mc == 0) ? b_tdata : q[0];
`else
            e_iv   = (mc != 0);
            e_pass = 1'b0;
            e_head = (mc == 0) ? 8'h00 : q[0];
`endif
            e_pop = e_iv && b_iready;
            check("rnd_ready", b_tready, (mc != 3));
            check("rnd_valid", b_ivalid, e_iv);
            if (e_iv) check("rnd_data", b_idata, e_head);
            tick();
            if (!e_pass) begin
                if (e_pop) void'(q.pop_front());
                if (e_push) q.push_back(b_tdata);
            end
            mc = q.size();
            check("rnd_count", b_count, mc);
        end
        quiet = 1'b0;
        b_tvalid = 1'b0;
        b_iready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
